// File: rtl/data_ram_responder_pkg.sv
// ============================================================================
// Package  : mem_map_pkg
// Desc     : Data-side memory map constants and responder state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_map_pkg;

    localparam int         RAM_WORDS  = 1024;
    localparam int         MMIO_WORDS = 16;
    localparam logic [9:0] MMIO_BASE  = 10'h3F0;
    localparam logic [3:0] MMIO_CYCLE = 4'd0;
    localparam logic [3:0] MMIO_GPIO  = 4'd1;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/data_ram_responder_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Desc     : Parameterized-width two-flop synchronizer, async active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/data_ram_responder.sv
// ============================================================================
// Module   : data_ram_responder
// Desc     : CPU data-port RAM with post-reset clear sweep and an MMIO window
//            holding a cycle counter and synchronized GPIO inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_responder #(
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    DATA_WIDTH     = 32,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE      = mem_map_pkg::MMIO_BASE
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] RAM_ADDR,
    input  logic [DATA_WIDTH-1:0] RAM_WRITE_DATA,
    input  logic                  RAM_WRITE_ENABLE,
    output logic [DATA_WIDTH-1:0] RAM_READ_DATA,
    output logic                  RAM_READY,
    input  logic [DATA_WIDTH-1:0] GPIO_IN
);

    import mem_map_pkg::*;

    localparam int                    c_words = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last  = '1;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_sweep;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [DATA_WIDTH-1:0] r_cycle;
    logic [DATA_WIDTH-1:0] r_mem [0:c_words-1];

    logic [DATA_WIDTH-1:0] w_gpio_sync;
    logic                  w_in_array;
    logic                  w_in_mmio;
    logic [ADDR_WIDTH-1:0] w_mmio_off;
    logic [3:0]            w_mmio_sel;
    logic                  w_cycle_wr;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    sync_2ff #(
        .WIDTH (DATA_WIDTH)
    ) u_gpio_sync (
        .clk (CLK),
        .rst (RST),
        .i_d (GPIO_IN),
        .o_q (w_gpio_sync)
    );

    // Address decode: array below the window, 16-word MMIO window above it.
    assign w_in_array = (RAM_ADDR < MMIO_BASE);
    assign w_mmio_off = RAM_ADDR - MMIO_BASE;
    assign w_in_mmio  = !w_in_array && (w_mmio_off < ADDR_WIDTH'(MMIO_WORDS));
    assign w_mmio_sel = w_mmio_off[3:0];
    assign w_cycle_wr = RAM_WRITE_ENABLE && w_in_mmio && (w_mmio_sel == MMIO_CYCLE);

    // The sweep owns the single write port until clearing finishes.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = RAM_ADDR;
        w_wr_data = RAM_WRITE_DATA;
        if (r_state == CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_sweep;
            w_wr_data = '0;
        end else begin
            w_wr_en   = RAM_WRITE_ENABLE && w_in_array;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_in_array) begin
            w_rd_mux = r_mem[RAM_ADDR];
        end else if (w_in_mmio) begin
            case (w_mmio_sel)
                MMIO_CYCLE: w_rd_mux = r_cycle;
                MMIO_GPIO:  w_rd_mux = w_gpio_sync;
                default:    w_rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= CLEAR_ON_RESET ? CLEAR : RUN;
            r_sweep     <= '0;
            r_ready     <= !CLEAR_ON_RESET;
            r_read_data <= '0;
            r_cycle     <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_read_data <= '0;
                    r_sweep     <= r_sweep + ADDR_WIDTH'(1);
                    if (r_sweep == c_last) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_read_data <= w_rd_mux;
                    // A store to CYCLE takes precedence over that edge's increment.
                    if (w_cycle_wr) begin
                        r_cycle <= RAM_WRITE_DATA;
                    end else begin
                        r_cycle <= r_cycle + DATA_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    assign RAM_READ_DATA = r_read_data;
    assign RAM_READY     = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_data_ram_responder.sv
// ============================================================================
// Module   : tb_data_ram_responder
// Desc     : Self-checking bench for data_ram_responder (clearing and non-clearing builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_ram_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [9:0]  RAM_ADDR = '0;
    logic [31:0] RAM_WRITE_DATA = '0;
    logic        RAM_WRITE_ENABLE = 1'b0;
    logic [31:0] RAM_READ_DATA;
    logic        RAM_READY;
    logic [31:0] GPIO_IN = '0;

    logic [9:0]  nc_addr = '0;
    logic [31:0] nc_wdata = '0;
    logic        nc_we = 1'b0;
    logic [31:0] nc_rd;
    logic        nc_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [0:1023];
    logic [31:0] cycle_m;
    logic [31:0] gpio_m;

    data_ram_responder #(.CLEAR_ON_RESET(1'b1)) dut (
        .CLK(CLK), .RST(RST), .RAM_ADDR(RAM_ADDR), .RAM_WRITE_DATA(RAM_WRITE_DATA),
        .RAM_WRITE_ENABLE(RAM_WRITE_ENABLE), .RAM_READ_DATA(RAM_READ_DATA),
        .RAM_READY(RAM_READY), .GPIO_IN(GPIO_IN)
    );

    data_ram_responder #(.CLEAR_ON_RESET(1'b0)) dut_nc (
        .CLK(CLK), .RST(RST), .RAM_ADDR(nc_addr), .RAM_WRITE_DATA(nc_wdata),
        .RAM_WRITE_ENABLE(nc_we), .RAM_READ_DATA(nc_rd),
        .RAM_READY(nc_ready), .GPIO_IN(GPIO_IN)
    );

    always #5 CLK = ~CLK;

    // Reference model: what a read of address a returns given current model state.
    function automatic logic [31:0] exp_read(input logic [9:0] a);
        logic [9:0] off;
        off = a - 10'h3F0;
        if (a < 10'h3F0) return mem_m[a];
        if (off == 10'd0) return cycle_m;
        if (off == 10'd1) return gpio_m;
        return 32'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
        cycle_m = 32'h0;
    endtask

    // One RUN-mode access: present inputs, take an edge, return model expectation.
    task automatic cycle_op(input logic [9:0] a, input logic [31:0] d, input logic w,
                            output logic [31:0] exp);
        RAM_ADDR = a;
        RAM_WRITE_DATA = d;
        RAM_WRITE_ENABLE = w;
        @(posedge CLK);
        exp = exp_read(a);
        if (w && a < 10'h3F0) mem_m[a] = d;
        if (w && a == 10'h3F0) cycle_m = d;
        else cycle_m = cycle_m + 32'd1;
        #1;
        RAM_WRITE_ENABLE = 1'b0;
    endtask

    task automatic sweep_count(output int edges, output bit rd_nonzero);
        edges = 0;
        rd_nonzero = 1'b0;
        for (int i = 1; i <= 1100; i++) begin
            @(posedge CLK);
            #1;
            if (RAM_READ_DATA !== 32'h0) rd_nonzero = 1'b1;
            if (RAM_READY === 1'b1) begin
                edges = i;
                break;
            end
        end
        RAM_WRITE_ENABLE = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        int  edges;
        bit  nz;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (RAM_READY !== 1'b0 || RAM_READ_DATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rd=%h, required ready=0 rd=0", RAM_READY, RAM_READ_DATA);
        end
        checks++;
        if (nc_ready !== 1'b1 || nc_rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_state_noclear: ready=%b rd=%h, required ready=1 rd=0", nc_ready, nc_rd);
        end
        // CPU stores during the sweep must be discarded.
        RAM_ADDR = 10'd5;
        RAM_WRITE_DATA = 32'hFFFF_FFFF;
        RAM_WRITE_ENABLE = 1'b1;
        RST = 1'b0;
        sweep_count(edges, nz);
        checks++;
        if (edges != 1024) begin
            errors++;
            $display("FAIL clear_latency: ready after %0d edges, required 1024", edges);
        end
        checks++;
        if (nz) begin
            errors++;
            $display("FAIL clear_read_zero: read data nonzero during sweep, required 0");
        end
    endtask

    task automatic test_clear_contents();
        logic [9:0]  addrs [5];
        logic [31:0] e;
        addrs = '{10'd0, 10'd5, 10'd511, 10'h3EF, 10'd1023};
        foreach (addrs[i]) begin
            cycle_op(addrs[i], 32'h0, 1'b0, e);
            checks++;
            if (RAM_READ_DATA !== e) begin
                errors++;
                $display("FAIL cleared_word[%0d]: got %h, required %h", addrs[i], RAM_READ_DATA, e);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] e;
        cycle_op(10'd5, 32'hDEAD_BEEF, 1'b1, e);
        cycle_op(10'd5, 32'h0, 1'b0, e);
        checks++;
        if (RAM_READ_DATA !== 32'hDEAD_BEEF || e !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_read: got %h, required %h", RAM_READ_DATA, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_read_first();
        logic [31:0] e;
        cycle_op(10'd6, 32'h1, 1'b1, e);
        checks++;
        if (RAM_READ_DATA !== e) begin
            errors++;
            $display("FAIL read_first_old: got %h, required %h", RAM_READ_DATA, e);
        end
        cycle_op(10'd6, 32'h0, 1'b0, e);
        checks++;
        if (RAM_READ_DATA !== e) begin
            errors++;
            $display("FAIL read_first_new: got %h, required %h", RAM_READ_DATA, e);
        end
    endtask

    task automatic test_cycle();
        logic [31:0] e;
        cycle_op(10'h3F0, 32'hFFFF_FFFE, 1'b1, e);
        checks++;
        if (RAM_READ_DATA !== e) begin
            errors++;
            $display("FAIL cycle_pre_load: got %h, required %h", RAM_READ_DATA, e);
        end
        // First read shows the loaded value, then the wrap FFFF_FFFF -> 0 -> 1.
        for (int i = 0; i < 4; i++) begin
            cycle_op(10'h3F0, 32'h0, 1'b0, e);
            checks++;
            if (RAM_READ_DATA !== e) begin
                errors++;
                $display("FAIL cycle_read[%0d]: got %h, required %h", i, RAM_READ_DATA, e);
            end
        end
    endtask

    task automatic test_gpio();
        logic [31:0] e;
        bit          seen;
        GPIO_IN = 32'hA5A5_0001;
        cycle_op(10'h3F1, 32'h0, 1'b0, e);
        checks++;
        if (RAM_READ_DATA !== 32'h0) begin
            errors++;
            $display("FAIL gpio_too_early: got %h, required %h", RAM_READ_DATA, 32'h0);
        end
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle_op(10'h3F1, 32'h0, 1'b0, e);
            if (RAM_READ_DATA === 32'hA5A5_0001) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL gpio_sync: got %h, required %h within 3 edges", RAM_READ_DATA, 32'hA5A5_0001);
        end
        gpio_m = 32'hA5A5_0001;
        cycle_op(10'h3F1, 32'h1234_5678, 1'b1, e);
        cycle_op(10'h3F1, 32'h0, 1'b0, e);
        checks++;
        if (RAM_READ_DATA !== e) begin
            errors++;
            $display("FAIL gpio_readonly: got %h, required %h", RAM_READ_DATA, e);
        end
        cycle_op(10'h3F7, 32'hFFFF_FFFF, 1'b1, e);
        cycle_op(10'h3F7, 32'h0, 1'b0, e);
        checks++;
        if (RAM_READ_DATA !== 32'h0) begin
            errors++;
            $display("FAIL mmio_reserved: got %h, required %h", RAM_READ_DATA, 32'h0);
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        logic [9:0]  a;
        int          r;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = 10'($urandom_range(0, 31));
            else if (r < 8) a = 10'($urandom_range(32, 10'h3EF));
            else            a = 10'h3F0 + 10'($urandom_range(0, 15));
            cycle_op(a, $urandom, 1'($urandom_range(0, 1)), e);
            checks++;
            if (RAM_READ_DATA !== e) begin
                errors++;
                $display("FAIL random[%0d] addr=%h: got %h, required %h", n, a, RAM_READ_DATA, e);
            end
        end
    endtask

    task automatic test_mid_run_reset();
        logic [31:0] e;
        cycle_op(10'h3F0, 32'h0, 1'b0, e);
        checks++;
        if (RAM_READ_DATA !== e) begin
            errors++;
            $display("FAIL cycle_before_reset: got %h, required %h", RAM_READ_DATA, e);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (RAM_READ_DATA !== 32'h0 || RAM_READY !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_run: rd=%h ready=%b, required rd=0 ready=0", RAM_READ_DATA, RAM_READY);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int          edges;
        bit          nz;
        logic [31:0] e;
        @(negedge CLK);
        RST = 1'b0;
        repeat (300) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        checks++;
        if (RAM_READY !== 1'b0 || RAM_READ_DATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_sweep: ready=%b rd=%h, required ready=0 rd=0", RAM_READY, RAM_READ_DATA);
        end
        @(negedge CLK);
        RST = 1'b0;
        sweep_count(edges, nz);
        checks++;
        if (edges != 1024) begin
            errors++;
            $display("FAIL resweep_latency: ready after %0d edges, required 1024", edges);
        end
        cycle_op(10'h3F0, 32'h0, 1'b0, e);
        checks++;
        if (RAM_READ_DATA !== e) begin
            errors++;
            $display("FAIL cycle_after_reset: got %h, required %h", RAM_READ_DATA, e);
        end
        cycle_op(10'd5, 32'h0, 1'b0, e);
        checks++;
        if (RAM_READ_DATA !== e) begin
            errors++;
            $display("FAIL resweep_word5: got %h, required %h", RAM_READ_DATA, e);
        end
    endtask

    task automatic test_no_clear();
        #2 RST = 1'b1;
        #1;
        checks++;
        if (nc_ready !== 1'b1 || nc_rd !== 32'h0) begin
            errors++;
            $display("FAIL noclear_reset: ready=%b rd=%h, required ready=1 rd=0", nc_ready, nc_rd);
        end
        @(negedge CLK);
        RST = 1'b0;
        nc_addr = 10'h3EF;
        nc_wdata = 32'hCAFE_F00D;
        nc_we = 1'b1;
        @(posedge CLK);
        #1;
        nc_we = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (nc_rd !== 32'hCAFE_F00D || nc_ready !== 1'b1) begin
            errors++;
            $display("FAIL noclear_first_edge: rd=%h ready=%b, required rd=cafef00d ready=1", nc_rd, nc_ready);
        end
        // Two RUN edges have elapsed since release, so CYCLE reads 2.
        nc_addr = 10'h3F0;
        @(posedge CLK);
        #1;
        checks++;
        if (nc_rd !== 32'd2) begin
            errors++;
            $display("FAIL noclear_cycle: got %h, required %h", nc_rd, 32'd2);
        end
        checks++;
        if (RAM_READY !== 1'b0) begin
            errors++;
            $display("FAIL clear_build_ready: got %b, required 0", RAM_READY);
        end
    endtask

    initial begin
        gpio_m = 32'h0;
        model_clear();
        test_reset();
        test_clear_contents();
        test_write_read();
        test_read_first();
        test_cycle();
        test_gpio();
        test_random();
        test_mid_run_reset();
        test_reset_mid_sweep();
        test_no_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
